// File: rtl/i2si_pkg.sv
// Shared defaults for the I2S input deserializer.
package i2si_pkg;

   localparam int WORD_W_DEF      = 16;
   localparam int SYNC_STAGES_DEF = 2;

   function automatic int cnt_w(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/i2si_deserializer_if.sv
// Serial input and parallel result bundle of the I2S input deserializer.
interface i2si_deserializer_if
   import i2si_pkg::*;
#(
   parameter int WORD_W = WORD_W_DEF
);

   logic              sck;
   logic              ws;
   logic              sd;
   logic              en;
   logic [WORD_W-1:0] lft;
   logic [WORD_W-1:0] rgt;
   logic              xfc;

   modport master (
      output sck, ws, sd, en,
      input  lft, rgt, xfc
   );

   modport slave (
      input  sck, ws, sd, en,
      output lft, rgt, xfc
   );

endinterface

// File: rtl/i2si_sync.sv
// Multi-flop synchronizer with a falling-edge pulse on the synced value.
module i2si_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q,
   output logic fall
);

   logic [STAGES-1:0] chain;
   logic              dly;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= '0;
         dly   <= 1'b0;
      end else begin
         chain <= (chain << 1) | STAGES'(d);
         dly   <= chain[STAGES-1];
      end
   end

   assign q    = chain[STAGES-1];
   assign fall = dly & ~q;

endmodule

// File: rtl/i2si_deserializer.sv
// I2S receiver: samples on sck falling edges, emits a left/right pair per frame.
module i2si_deserializer
   import i2si_pkg::*;
#(
   parameter int WORD_W      = WORD_W_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i2si_sck,
   input  logic              i2si_ws,
   input  logic              i2si_sd,
   input  logic              rf_i2si_en,
   output logic [WORD_W-1:0] i2si_lft,
   output logic [WORD_W-1:0] i2si_rgt,
   output logic              i2si_xfc
);

   localparam int CW = cnt_w(WORD_W);
   localparam logic [CW-1:0] FULL = CW'(WORD_W);

   logic sck_fall;
   logic ws_s;
   logic sd_s;
   logic unused_sck_q;
   logic unused_ws_fall;
   logic unused_sd_fall;

   i2si_sync #(.STAGES(SYNC_STAGES)) u_sck (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (i2si_sck),
      .q    (unused_sck_q),
      .fall (sck_fall)
   );

   i2si_sync #(.STAGES(SYNC_STAGES)) u_ws (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (i2si_ws),
      .q    (ws_s),
      .fall (unused_ws_fall)
   );

   i2si_sync #(.STAGES(SYNC_STAGES)) u_sd (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (i2si_sd),
      .q    (sd_s),
      .fall (unused_sd_fall)
   );

   logic [WORD_W-1:0] shift;
   logic [WORD_W-1:0] lhold;
   logic [CW-1:0]     cnt;
   logic              lvalid;
   logic              armed;
   logic              prev_ok;
   logic              ws_prev;

   logic              tog;
   logic              start;
   logic              active;
   logic              accept;
   logic              done;
   logic [WORD_W-1:0] nxt_shift;
   logic [CW-1:0]     nxt_cnt;

   // prev_ok stops the first sample after enable from looking like a toggle
   always_comb begin
      tog       = prev_ok && (ws_s != ws_prev);
      start     = tog && ws_s;
      active    = armed || start;
      accept    = tog || (cnt < FULL);
      nxt_shift = tog ? WORD_W'(sd_s)
                      : ((shift << 1) | WORD_W'(sd_s));
      nxt_cnt   = tog ? CW'(1) : cnt + CW'(1);
      done      = accept && (nxt_cnt == FULL);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift    <= '0;
         lhold    <= '0;
         cnt      <= '0;
         lvalid   <= 1'b0;
         armed    <= 1'b0;
         prev_ok  <= 1'b0;
         ws_prev  <= 1'b0;
         i2si_lft <= '0;
         i2si_rgt <= '0;
         i2si_xfc <= 1'b0;
      end else begin
         i2si_xfc <= 1'b0;
         if (!rf_i2si_en) begin
            shift   <= '0;
            cnt     <= '0;
            lvalid  <= 1'b0;
            armed   <= 1'b0;
            prev_ok <= 1'b0;
            ws_prev <= 1'b0;
         end else if (sck_fall) begin
            prev_ok <= 1'b1;
            ws_prev <= ws_s;
            if (active) begin
               armed <= 1'b1;
               if (accept) begin
                  shift <= nxt_shift;
                  cnt   <= nxt_cnt;
               end
               // a new left word or a short left word kills the frame
               if (tog && (ws_s || cnt != FULL))
                  lvalid <= 1'b0;
               if (done && ws_s) begin
                  lhold  <= nxt_shift;
                  lvalid <= 1'b1;
               end else if (done && lvalid) begin
                  i2si_lft <= lhold;
                  i2si_rgt <= nxt_shift;
                  i2si_xfc <= 1'b1;
                  lvalid   <= 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_i2si_deserializer.sv
// Scoreboard bench for i2si_deserializer: directed frames and abort cases.
module tb_i2si_deserializer;
   import i2si_pkg::*;

   localparam int W = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   i2si_deserializer_if #(.WORD_W(W)) bus ();

   i2si_deserializer #(.WORD_W(W), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i2si_sck  (bus.sck),
      .i2si_ws   (bus.ws),
      .i2si_sd   (bus.sd),
      .rf_i2si_en(bus.en),
      .i2si_lft  (bus.lft),
      .i2si_rgt  (bus.rgt),
      .i2si_xfc  (bus.xfc)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int half     = 400;

   logic [2*W-1:0] sb[$];
   logic [2*W-1:0] mon_exp;
   logic [W-1:0]   last_l = '0;
   logic [W-1:0]   last_r = '0;
   logic           last_x = 1'b0;
   logic [W-1:0]   hold_l;
   logic [W-1:0]   hold_r;

   logic [W-1:0] tl [11] = '{16'h1478, 16'hCDD7, 16'h0001, 16'h69D9,
                             16'h8000, 16'hFFFF, 16'h1234, 16'hDEAD,
                             16'h7FFF, 16'h5555, 16'h0F0F};
   logic [W-1:0] tr [11] = '{16'hA3B9, 16'hBABA, 16'hFFFF, 16'hABCD,
                             16'h0001, 16'h0000, 16'h5678, 16'hBEEF,
                             16'h8000, 16'hAAAA, 16'hF0F0};

   task automatic chk(input string name, input logic [W-1:0] act,
                      input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         last_l = '0;
         last_r = '0;
         last_x = 1'b0;
      end else begin
         if (bus.xfc) begin
            checks++;
            if (last_x) begin
               failures++;
               $display("FAIL xfc_width actual=2+ cycles required=1");
            end
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL unexpected_xfc actual=%h/%h required=none",
                        bus.lft, bus.rgt);
            end else begin
               mon_exp = sb.pop_front();
               chk("sb_lft", bus.lft, mon_exp[2*W-1:W]);
               chk("sb_rgt", bus.rgt, mon_exp[W-1:0]);
            end
         end else if (bus.lft !== last_l || bus.rgt !== last_r) begin
            failures++;
            $display("FAIL hold actual=%h/%h required=%h/%h",
                     bus.lft, bus.rgt, last_l, last_r);
         end
         last_l = bus.lft;
         last_r = bus.rgt;
         last_x = bus.xfc;
      end
   end

   task automatic bit_out(input logic w, input logic d);
      bus.sck = 1'b1;
      #20;
      bus.ws = w;
      bus.sd = d;
      #(half - 20);
      bus.sck = 1'b0;
      #(half);
   endtask

   task automatic word_out(input logic w, input logic [W-1:0] v,
                           input int first, input int last);
      for (int i = first; i < last; i++)
         bit_out(w, v[W-1-i]);
   endtask

   task automatic frame(input logic [W-1:0] l, input logic [W-1:0] r);
      word_out(1'b1, l, 0, W);
      word_out(1'b0, r, 0, W);
   endtask

   task automatic preamble();
      bit_out(1'b0, 1'b0);
      bit_out(1'b0, 1'b0);
   endtask

   task automatic drain(input string name);
      int t = 0;
      while (sb.size() != 0 && t < 5000) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL %s pending=%0d required=0", name, sb.size());
         sb.delete();
      end
      repeat (10) @(negedge clk);
   endtask

   initial begin
      bus.sck = 1'b0;
      bus.ws  = 1'b0;
      bus.sd  = 1'b0;
      bus.en  = 1'b1;
      #22;
      chk("rst_lft", bus.lft, '0);
      chk("rst_rgt", bus.rgt, '0);
      chk("rst_xfc", W'(bus.xfc), '0);
      rst_n = 1'b1;
      #8;

      // basic frame at the slow bit clock
      sb.push_back({16'hAAAA, 16'hFFFF});
      preamble();
      frame(16'hAAAA, 16'hFFFF);
      drain("drain_basic");
      chk("basic_lft", bus.lft, 16'hAAAA);
      chk("basic_rgt", bus.rgt, 16'hFFFF);

      half = 80;
      for (int i = 0; i < 11; i++)
         sb.push_back({tl[i], tr[i]});
      for (int i = 0; i < 11; i++)
         frame(tl[i], tr[i]);
      drain("drain_b2b");
      chk("b2b_lft", bus.lft, 16'h0F0F);
      chk("b2b_rgt", bus.rgt, 16'hF0F0);

      // enable raised in the middle of a left word
      bus.en = 1'b0;
      word_out(1'b1, 16'h1357, 0, 6);
      bus.en = 1'b1;
      word_out(1'b1, 16'h1357, 6, W);
      word_out(1'b0, 16'h2468, 0, W);
      repeat (10) @(negedge clk);
      chk("en_mid_lft", bus.lft, 16'h0F0F);
      chk("en_mid_rgt", bus.rgt, 16'hF0F0);
      sb.push_back({16'hC0DE, 16'hF00D});
      frame(16'hC0DE, 16'hF00D);
      drain("drain_en_mid");

      // short left word drops the frame
      word_out(1'b1, 16'h9999, 0, 10);
      word_out(1'b0, 16'h4444, 0, W);
      repeat (10) @(negedge clk);
      chk("short_lft", bus.lft, 16'hC0DE);
      chk("short_rgt", bus.rgt, 16'hF00D);
      sb.push_back({16'h3C3C, 16'hC3C3});
      frame(16'h3C3C, 16'hC3C3);
      drain("drain_short");

      // reset in the middle of a right word
      word_out(1'b1, 16'h1111, 0, W);
      word_out(1'b0, 16'h2222, 0, 8);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mrst_lft", bus.lft, '0);
      chk("mrst_rgt", bus.rgt, '0);
      chk("mrst_xfc", W'(bus.xfc), '0);
      #50;
      rst_n = 1'b1;
      preamble();
      sb.push_back({16'h0BAD, 16'hCAFE});
      frame(16'h0BAD, 16'hCAFE);
      drain("drain_mrst");

      // enable dropped mid-frame
      hold_l = bus.lft;
      hold_r = bus.rgt;
      word_out(1'b1, 16'h7777, 0, W);
      word_out(1'b0, 16'h8888, 0, 8);
      bus.en = 1'b0;
      word_out(1'b0, 16'h8888, 8, W);
      repeat (10) @(negedge clk);
      chk("dis_lft", bus.lft, 16'h0BAD);
      chk("dis_rgt", bus.rgt, 16'hCAFE);
      chk("dis_hold", bus.rgt, hold_r);
      chk("dis_holdl", bus.lft, hold_l);
      bus.en = 1'b1;
      preamble();
      sb.push_back({16'h4321, 16'h8765});
      frame(16'h4321, 16'h8765);
      drain("drain_dis");
      chk("end_lft", bus.lft, 16'h4321);
      chk("end_rgt", bus.rgt, 16'h8765);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
